// File: rtl/multi_cam_capture.sv
// multi_cam_capture: selects one of NUM_CAMS pre-synchronised camera byte
// streams and frames the bytes into RGB565 or 8-bit grey pixels. Each pixel
// comes with its frame-buffer write address and its line/column position.
// Camera switching, grey-mode changes and freeze take effect only at frame
// boundaries, which are the vsync rises of the active camera.
module multi_cam_capture #(
  parameter int NUM_CAMS = 2,
  parameter int H_PIXELS = 320,
  parameter int V_PIXELS = 240,
  parameter int ADDR_W   = 17,
  localparam int SEL_W   = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [8*NUM_CAMS-1:0] cam_data_in,
  input  logic [3*NUM_CAMS-1:0] cam_sync_in,
  input  logic [SEL_W-1:0]      cam_sel_in,
  input  logic                  grey_mode_in,
  input  logic                  freeze_req_in,
  output logic [15:0]           pixel_out,
  output logic [ADDR_W-1:0]     addr_out,
  output logic [10:0]           hcount_out,
  output logic [9:0]            vcount_out,
  output logic                  we_out,
  output logic                  frame_done_out,
  output logic                  frozen_out,
  output logic [SEL_W-1:0]      active_cam_out,
  output logic                  overflow_out
);

  typedef enum logic [1:0] {LIVE, FRZ_PEND, FROZEN, THAW_PEND} frz_state_e;

  frz_state_e        state_q, state_d;
  logic [SEL_W-1:0]  activeCam_q;
  logic [7:0]        data_q;
  logic              pclk_q, vsync_q, href_q;
  logic              pclkPrev_q, vsyncPrev_q, hrefPrev_q;
  logic              phase_q;
  logic [7:0]        hiByte_q;
  logic [10:0]       hcount_q;
  logic [9:0]        vcount_q;
  logic [ADDR_W-1:0] lineBase_q;
  logic              greyMode_q;
  logic              capEn_q;
  logic              pixelSeen_q;
  logic [15:0]       pixel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [10:0]       hcnt_q;
  logic [9:0]        vcnt_q;
  logic              we_q;
  logic              frameDone_q;
  logic              overflow_q;

  logic [7:0]  muxData;
  logic        muxPclk, muxVsync, muxHref;
  logic        pclkRise, boundary, hrefFall, capture, formPixel;
  logic        selValid, camSwitch, inRange, frozenNow;
  logic [15:0] pixelNow, pixelFmt, yAcc;
  logic [7:0]  r8, g8, b8;

  // Route the lanes of the currently captured camera to the sampling stage.
  always_comb begin
    muxData  = '0;
    muxPclk  = 1'b0;
    muxVsync = 1'b0;
    muxHref  = 1'b0;
    for (int k = 0; k < NUM_CAMS; k++) begin
      if (activeCam_q == SEL_W'(k)) begin
        muxData  = cam_data_in[8*k +: 8];
        muxPclk  = cam_sync_in[3*k];
        muxVsync = cam_sync_in[3*k+1];
        muxHref  = cam_sync_in[3*k+2];
      end
    end
  end

  assign pclkRise  = pclk_q & ~pclkPrev_q;
  assign boundary  = vsync_q & ~vsyncPrev_q;
  assign hrefFall  = hrefPrev_q & ~href_q;
  // A vsync rise wins over a coincident pclk rise; that byte is discarded.
  assign capture   = pclkRise & href_q & ~boundary;
  assign formPixel = capture & phase_q;
  assign selValid  = int'(cam_sel_in) < NUM_CAMS;
  assign camSwitch = boundary & selValid & (cam_sel_in != activeCam_q);
  assign inRange   = (int'(hcount_q) < H_PIXELS) && (int'(vcount_q) < V_PIXELS);
  assign frozenNow = (state_q == FROZEN) || (state_q == THAW_PEND);
  assign pixelNow  = {hiByte_q, data_q};

  // Convert the freshly formed RGB565 pixel to luma with widened channels.
  always_comb begin
    r8       = {pixelNow[15:11], pixelNow[15:13]};
    g8       = {pixelNow[10:5], pixelNow[10:9]};
    b8       = {pixelNow[4:0], pixelNow[4:2]};
    yAcc     = 16'(r8) * 16'd77 + 16'(g8) * 16'd150 + 16'(b8) * 16'd29;
    pixelFmt = greyMode_q ? {8'h00, yAcc[15:8]} : pixelNow;
  end

  // Sample the active lanes and keep previous levels for edge detection;
  // a camera switch clears the history so the new camera starts clean.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      data_q      <= '0;
      pclk_q      <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      pclkPrev_q  <= 1'b0;
      vsyncPrev_q <= 1'b0;
      hrefPrev_q  <= 1'b0;
    end else if (camSwitch) begin
      data_q      <= '0;
      pclk_q      <= 1'b0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      pclkPrev_q  <= 1'b0;
      vsyncPrev_q <= 1'b0;
      hrefPrev_q  <= 1'b0;
    end else begin
      data_q      <= muxData;
      pclk_q      <= muxPclk;
      vsync_q     <= muxVsync;
      href_q      <= muxHref;
      pclkPrev_q  <= pclk_q;
      vsyncPrev_q <= vsync_q;
      hrefPrev_q  <= href_q;
    end
  end

  // Byte framing plus line/column tracking; frame boundaries restart everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      phase_q    <= 1'b0;
      hiByte_q   <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      lineBase_q <= '0;
    end else if (boundary) begin
      phase_q    <= 1'b0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      lineBase_q <= '0;
    end else if (hrefFall) begin
      phase_q    <= 1'b0;
      hcount_q   <= '0;
      lineBase_q <= lineBase_q + ADDR_W'(H_PIXELS);
      if (vcount_q != '1) vcount_q <= vcount_q + 10'd1;
    end else if (capture) begin
      phase_q <= ~phase_q;
      if (!phase_q) hiByte_q <= data_q;
      else if (hcount_q != '1) hcount_q <= hcount_q + 11'd1;
    end
  end

  // Per-frame settings that only change at a boundary.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      activeCam_q <= '0;
      greyMode_q  <= 1'b0;
      capEn_q     <= 1'b0;
      pixelSeen_q <= 1'b0;
    end else if (boundary) begin
      if (selValid) activeCam_q <= cam_sel_in;
      greyMode_q  <= grey_mode_in;
      capEn_q     <= 1'b1;
      pixelSeen_q <= 1'b0;
    end else if (formPixel) begin
      pixelSeen_q <= 1'b1;
    end
  end

  // Registered pixel output stage toward the frame-buffer write port.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_q     <= '0;
      addr_q      <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      we_q        <= 1'b0;
      frameDone_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      we_q        <= formPixel & inRange & capEn_q & ~frozenNow;
      frameDone_q <= boundary & pixelSeen_q;
      if (formPixel) begin
        pixel_q <= pixelFmt;
        addr_q  <= lineBase_q + ADDR_W'(hcount_q);
        hcnt_q  <= hcount_q;
        vcnt_q  <= vcount_q;
      end
      if (boundary) overflow_q <= 1'b0;
      else if (formPixel && !inRange) overflow_q <= 1'b1;
    end
  end

  // Freeze state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= LIVE;
    else        state_q <= state_d;
  end

  // Freeze sequencing: entering and leaving the frozen condition waits for a
  // frame boundary, while a withdrawn request cancels a pending transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LIVE:      if (freeze_req_in) state_d = FRZ_PEND;
      FRZ_PEND:  if (!freeze_req_in) state_d = LIVE;
                 else if (boundary) state_d = FROZEN;
      FROZEN:    if (!freeze_req_in) state_d = THAW_PEND;
      THAW_PEND: if (freeze_req_in) state_d = FROZEN;
                 else if (boundary) state_d = LIVE;
      default:   state_d = LIVE;
    endcase
  end

  assign pixel_out      = pixel_q;
  assign addr_out       = addr_q;
  assign hcount_out     = hcnt_q;
  assign vcount_out     = vcnt_q;
  assign we_out         = we_q;
  assign frame_done_out = frameDone_q;
  assign frozen_out     = frozenNow;
  assign active_cam_out = activeCam_q;
  assign overflow_out   = overflow_q;

endmodule

// File: tb/tb_multi_cam_capture.sv
// tb_multi_cam_capture: drives three camera streams and checks the captured
// writes against a frame-level model of what each frame should store.
module tb_multi_cam_capture;

  localparam int NUM_CAMS = 3;
  localparam int H        = 4;
  localparam int V        = 2;
  localparam int AW       = 17;
  localparam int SW       = 2;

  typedef struct {
    logic [15:0]   pix;
    logic [AW-1:0] addr;
    logic [10:0]   h;
    logic [9:0]    v;
  } wr_t;

  typedef struct {
    logic        grey;
    logic [15:0] pix;
    logic [15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cData [NUM_CAMS];
  logic       cPclk [NUM_CAMS];
  logic       cVs   [NUM_CAMS];
  logic       cHref [NUM_CAMS];
  logic [8*NUM_CAMS-1:0] camData;
  logic [3*NUM_CAMS-1:0] camSync;
  logic [SW-1:0] camSel    = '0;
  logic          grey      = 1'b0;
  logic          freezeReq = 1'b0;

  logic [15:0]   pixelOut;
  logic [AW-1:0] addrOut;
  logic [10:0]   hcountOut;
  logic [9:0]    vcountOut;
  logic          weOut, frameDoneOut, frozenOut, overflowOut;
  logic [SW-1:0] activeCamOut;

  int compared   = 0;
  int mismatched = 0;
  int wrCount    = 0;
  int fdCount    = 0;
  logic [15:0] lastPix = '0;
  wr_t gotQ[$];
  wr_t expQ[$];

  // Frame-level model state
  int   mActive   = 0;
  int   mLine     = 0;
  int   mPixCount = 0;
  int   mFd       = 0;
  logic mGrey     = 1'b0;
  logic mEnable   = 1'b0;
  logic mFrozen   = 1'b0;
  logic mOvf      = 1'b0;

  multi_cam_capture #(
    .NUM_CAMS(NUM_CAMS), .H_PIXELS(H), .V_PIXELS(V), .ADDR_W(AW)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .cam_data_in(camData), .cam_sync_in(camSync),
    .cam_sel_in(camSel), .grey_mode_in(grey), .freeze_req_in(freezeReq),
    .pixel_out(pixelOut), .addr_out(addrOut),
    .hcount_out(hcountOut), .vcount_out(vcountOut),
    .we_out(weOut), .frame_done_out(frameDoneOut), .frozen_out(frozenOut),
    .active_cam_out(activeCamOut), .overflow_out(overflowOut)
  );

  always #5 clk = ~clk;

  // Pack the per-camera signals into the lane layout of the design.
  always_comb begin
    camData = '0;
    camSync = '0;
    for (int k = 0; k < NUM_CAMS; k++) begin
      camData[8*k +: 8] = cData[k];
      camSync[3*k]      = cPclk[k];
      camSync[3*k+1]    = cVs[k];
      camSync[3*k+2]    = cHref[k];
    end
  end

  // Record every write strobe and frame-done pulse away from the clock edge.
  always @(negedge clk) begin
    if (weOut) begin
      wrCount++;
      lastPix = pixelOut;
      gotQ.push_back('{pixelOut, addrOut, hcountOut, vcountOut});
    end
    if (frameDoneOut) fdCount++;
  end

  // Guard against a stalled run.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] greyOf(logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 16'((r * 77 + g * 150 + b * 29) / 256);
  endfunction

  task automatic sendByte(int cam, logic [7:0] b);
    cData[cam] = b;
    cPclk[cam] = 1'b0;
    tick(2);
    cPclk[cam] = 1'b1;
    tick(2);
    cPclk[cam] = 1'b0;
  endtask

  // Sends one href-framed line and updates the model with its pixels.
  task automatic applyStimulus(int cam, logic [7:0] bytes[$]);
    logic [15:0] p;
    cHref[cam] = 1'b1;
    tick(2);
    foreach (bytes[i]) sendByte(cam, bytes[i]);
    tick(1);
    cHref[cam] = 1'b0;
    tick(4);
    if (cam == mActive) begin
      for (int h = 0; h < bytes.size() / 2; h++) begin
        p = {bytes[2*h], bytes[2*h+1]};
        mPixCount++;
        if (h >= H || mLine >= V) mOvf = 1'b1;
        else if (mEnable && !mFrozen)
          expQ.push_back('{mGrey ? greyOf(p) : p, AW'(mLine * H + h), 11'(h), 10'(mLine)});
      end
      mLine++;
    end
  endtask

  task automatic modelBoundary();
    if (mPixCount > 0) mFd++;
    mPixCount = 0;
    mLine     = 0;
    mOvf      = 1'b0;
    mGrey     = grey;
    mEnable   = 1'b1;
    mFrozen   = freezeReq;
    if (int'(camSel) < NUM_CAMS) mActive = int'(camSel);
  endtask

  task automatic sendVsync(int cam);
    cVs[cam] = 1'b1;
    tick(4);
    cVs[cam] = 1'b0;
    tick(3);
    if (cam == mActive) modelBoundary();
  endtask

  task automatic patternLine(int cam, int nPix, logic [15:0] p);
    logic [7:0] q[$];
    for (int i = 0; i < nPix; i++) begin
      q.push_back(p[15:8]);
      q.push_back(p[7:0]);
    end
    applyStimulus(cam, q);
  endtask

  task automatic randomLine(int cam, int nPix);
    logic [7:0] q[$];
    for (int i = 0; i < 2 * nPix; i++) q.push_back(8'($urandom_range(0, 255)));
    applyStimulus(cam, q);
  endtask

  task automatic drainWrites(string tag);
    int n;
    wr_t g, e;
    checkOutput({tag, "_nwrites"}, gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      g = gotQ.pop_front();
      e = expQ.pop_front();
      checkOutput({tag, "_pixel"}, g.pix, e.pix);
      checkOutput({tag, "_addr"}, g.addr, e.addr);
      checkOutput({tag, "_hv"}, {g.h, g.v}, {e.h, e.v});
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic checkResetState(string tag);
    checkOutput({tag, "_pixel"}, pixelOut, 0);
    checkOutput({tag, "_addr"}, addrOut, 0);
    checkOutput({tag, "_hv"}, {hcountOut, vcountOut}, 0);
    checkOutput({tag, "_we"}, weOut, 0);
    checkOutput({tag, "_frame_done"}, frameDoneOut, 0);
    checkOutput({tag, "_frozen"}, frozenOut, 0);
    checkOutput({tag, "_active_cam"}, activeCamOut, 0);
    checkOutput({tag, "_overflow"}, overflowOut, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   wr0, fd0, nLines;

    vecs[0] = '{1'b0, 16'hF800, 16'hF800};
    vecs[1] = '{1'b0, 16'h1234, 16'h1234};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h00FF};
    vecs[3] = '{1'b1, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 16'hF800, 16'h004C};
    vecs[5] = '{1'b1, 16'h07E0, 16'h0095};
    vecs[6] = '{1'b1, 16'h001F, 16'h001C};
    vecs[7] = '{1'b1, 16'h8410, 16'h0082};

    for (int k = 0; k < NUM_CAMS; k++) begin
      cData[k] = '0; cPclk[k] = 1'b0; cVs[k] = 1'b0; cHref[k] = 1'b0;
    end
    tick(3);
    checkResetState("reset");
    rst = 1'b0;
    tick(2);

    // 4x2 frame of 0xF800
    sendVsync(0);
    wr0 = wrCount; fd0 = fdCount;
    patternLine(0, 4, 16'hF800);
    patternLine(0, 4, 16'hF800);
    sendVsync(0);
    checkOutput("basic_write_count", wrCount - wr0, 8);
    checkOutput("basic_frame_done", fdCount - fd0, 1);
    drainWrites("basic");

    // Table of single-pixel frames in RGB and grey modes
    for (int i = 0; i < 8; i++) begin
      grey = vecs[i].grey;
      sendVsync(0);
      patternLine(0, 1, vecs[i].pix);
      checkOutput($sformatf("vec%0d_pixel", i), lastPix, vecs[i].exp);
      drainWrites($sformatf("vec%0d", i));
    end
    grey = 1'b0;

    // Too many pixels on a line, then too many lines
    sendVsync(0);
    patternLine(0, 6, 16'hABCD);
    checkOutput("ovf_h_set", overflowOut, 1);
    sendVsync(0);
    checkOutput("ovf_h_clear", overflowOut, 0);
    patternLine(0, 2, 16'h1111);
    patternLine(0, 2, 16'h2222);
    checkOutput("ovf_v_before", overflowOut, 0);
    patternLine(0, 2, 16'h3333);
    checkOutput("ovf_v_set", overflowOut, 1);
    sendVsync(0);
    checkOutput("ovf_v_clear", overflowOut, 0);
    drainWrites("ovf");

    // vsync and pclk rising together: the byte is dropped
    cHref[0] = 1'b1;
    tick(2);
    sendByte(0, 8'hF8);
    cData[0] = 8'h00;
    tick(2);
    cPclk[0] = 1'b1;
    cVs[0]   = 1'b1;
    tick(3);
    cPclk[0] = 1'b0;
    cVs[0]   = 1'b0;
    tick(2);
    modelBoundary();
    sendByte(0, 8'h12);
    sendByte(0, 8'h34);
    tick(1);
    cHref[0] = 1'b0;
    tick(4);
    expQ.push_back('{16'h1234, AW'(0), 11'd0, 10'd0});
    mPixCount++;
    mLine++;
    drainWrites("tie");

    // Randomized frames against the model
    for (int f = 0; f < 12; f++) begin
      grey = 1'($urandom_range(0, 1));
      sendVsync(0);
      nLines = $urandom_range(0, 3);
      for (int l = 0; l < nLines; l++) randomLine(0, $urandom_range(1, 6));
      checkOutput($sformatf("rand%0d_overflow", f), overflowOut, mOvf);
      drainWrites($sformatf("rand%0d", f));
    end
    grey = 1'b0;
    sendVsync(0);
    checkOutput("rand_frame_done", fdCount, mFd);

    // Camera switch requested mid-frame
    randomLine(0, 2);
    camSel = 2'd1;
    tick(2);
    checkOutput("sel_pending_cam", activeCamOut, 0);
    randomLine(1, 3);
    randomLine(0, 3);
    sendVsync(0);
    checkOutput("sel_applied_cam", activeCamOut, 1);
    randomLine(1, 4);
    camSel = 2'd3;
    sendVsync(1);
    checkOutput("sel_invalid_cam", activeCamOut, 1);
    randomLine(1, 2);
    camSel = 2'd0;
    sendVsync(1);
    checkOutput("sel_back_cam", activeCamOut, 0);
    drainWrites("sel");

    // Freeze request held across a boundary, then released
    randomLine(0, 2);
    freezeReq = 1'b1;
    tick(2);
    checkOutput("frz_pending", frozenOut, 0);
    randomLine(0, 2);
    sendVsync(0);
    checkOutput("frz_frozen", frozenOut, 1);
    randomLine(0, 3);
    freezeReq = 1'b0;
    tick(2);
    checkOutput("frz_thaw_pending", frozenOut, 1);
    randomLine(0, 3);
    sendVsync(0);
    checkOutput("frz_live", frozenOut, 0);
    randomLine(0, 3);
    freezeReq = 1'b1;
    tick(3);
    freezeReq = 1'b0;
    tick(2);
    sendVsync(0);
    checkOutput("frz_cancelled", frozenOut, 0);
    randomLine(0, 2);
    drainWrites("frz");
    checkOutput("frz_frame_done", fdCount, mFd);

    // Asynchronous reset in the middle of a line on camera 1 while frozen
    camSel = 2'd1;
    sendVsync(0);
    randomLine(1, 2);
    randomLine(1, 2);
    freezeReq = 1'b1;
    sendVsync(1);
    checkOutput("pre_reset_frozen", frozenOut, 1);
    drainWrites("pre_reset");
    cHref[1] = 1'b1;
    tick(2);
    sendByte(1, 8'hAB);
    #2;
    rst = 1'b1;
    #1;
    checkResetState("midreset");
    cHref[1]  = 1'b0;
    freezeReq = 1'b0;
    camSel    = 2'd0;
    tick(3);
    rst = 1'b0;
    gotQ.delete();
    expQ.delete();
    mActive = 0; mLine = 0; mPixCount = 0; mGrey = 1'b0;
    mEnable = 1'b0; mFrozen = 1'b0; mOvf = 1'b0;
    tick(2);
    wr0 = wrCount; fd0 = fdCount;
    patternLine(0, 2, 16'h5A5A);
    checkOutput("post_reset_held", wrCount - wr0, 0);
    sendVsync(0);
    checkOutput("post_reset_frame_done", fdCount - fd0, 1);
    randomLine(0, 3);
    drainWrites("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
